pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage DataCycle core (IF/ID/EX/MEM/WB). Drives the currently unconnected stall/flush inputs of pc and pipeline registers p1..p4.
- Tracks in-flight register writes in its own 3-entry scoreboard and stalls ID on read-after-write hazards. The regfile has no bypass, and WB writes on the clock edge.
- Holds fetch in the shadow of a control-transfer instruction until branchlogic resolves MP0 in WB.
- Honours an external memory hold.

Parameters:
- RIDX_W, 5, register index width.
- BR_SHADOW, 3, cycles a control-transfer spends from EX to WB (shadow length).
- ZERO_REG, 1, 1 = register 0 never creates a hazard.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rx  in  RIDX_W  ID source index Rx.
- id_ry  in  RIDX_W  ID source index Ry.
- id_rx_used  in  1  ID instruction reads Rx.
- id_ry_used  in  1  ID instruction reads Ry.
- id_rz  in  RIDX_W  ID destination (IDmp1_out).
- id_rin  in  1  ID instruction writes regfile.
- id_is_ctrl  in  1  ID instruction redirects via branchlogic.
- wb_mp0  in  1  branchlogic MP0 (taken) from WB.
- ext_hold  in  1  data memory not ready; freeze whole pipe.
- pc_stall  out  1  hold PC.
- p1_stall, p2_stall, p3_stall, p4_stall  out  1 each  hold pipeline register.
- p1_flush, p2_flush  out  1 each  load bubble into ID / EX.
- ctrl_state  out  2  00 RUN, 01 SHADOW, 10 HOLD.

Behaviour:
- Reset (rst=0, async): state=RUN, shadow counter=0, all scoreboard entries invalid, so every stall/flush output is 0.
- All stall/flush outputs are combinational from state, scoreboard and inputs.
- Scoreboard: entries sbEX, sbMEM, sbWB, each {valid, idx}.
  - Per clock unless frozen: sbWB<=sbMEM, sbMEM<=sbEX.
  - sbEX<={issue & id_rin & !(ZERO_REG & id_rz==0), id_rz}.
  - issue = ID instruction enters EX this cycle (p2_flush=0 and not frozen).
- hazard = (id_rx_used & match(id_rx)) | (id_ry_used & match(id_ry)).
  - match(r) is true if any valid entry has idx==r.
  - With ZERO_REG=1, r==0 never matches.
- RUN:
  - If hazard: pc_stall=p1_stall=1, p2_flush=1 (bubble into EX).
  - Else if id_is_ctrl: issue normally, load counter=BR_SHADOW-1, go to SHADOW.
  - Else all outputs 0.
- SHADOW (ID holds the fall-through instruction b+1, IF holds b+2):
  - Counter!=0: pc_stall=p1_stall=1, p2_flush=1, decrement counter.
  - Counter==0 (branch in WB), wb_mp0=1: pc_stall=0 (PC loads WB target), p1_flush=1, p2_flush=1, go to RUN.
  - Counter==0, wb_mp0=0: go to RUN and evaluate the RUN equations in this same cycle. b+1 may issue, stall on a hazard, or start a new SHADOW.
- HOLD: entered from any state when ext_hold=1.
  - pc_stall and p1..p4_stall all =1, all flushes=0.
  - Scoreboard and counter frozen; previous state saved.
  - Returns to the saved state on the first cycle with ext_hold=0.
- Priority: ext_hold > SHADOW resolution > hazard > id_is_ctrl issue.
- A control-transfer instruction with a hazard stays in ID until the hazard clears; it does not enter SHADOW while stalled.
- wb_mp0 is ignored outside the SHADOW resolution cycle.
- Reset mid-SHADOW or mid-HOLD returns to RUN immediately; no resolution is pending.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[15:0] and redirect_cnt[15:0].
  - stall_cnt increments on every cycle with pc_stall=1.
  - redirect_cnt increments on every taken resolution.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: drive rst=0 mid-SHADOW with counter=2 -> ctrl_state=00 and all stall/flush=0 immediately; after release, no stale hazard against r5.
- RAW: issue write r3, next ID reads r3 via Rx -> pc_stall=p1_stall=p2_flush=1 for exactly 3 cycles, then the consumer issues; reading r0 after a write to r0 causes no stall.
- Taken branch: issue ctrl with no hazard, wb_mp0=1 at counter==0.
  - Required: 2 cycles of pc_stall, then 1 cycle pc_stall=0, p1_flush=1, p2_flush=1.
  - b+1 never reaches EX.
- Not taken: same sequence with wb_mp0=0 -> the cycle after the shadow, b+1 issues (all outputs 0); sbEX receives b+1's destination.
- ext_hold: assert for 4 cycles during SHADOW (counter=1).
  - Required: all stalls=1, counter frozen.
  - Resolution occurs 1 cycle after hold drops.
- HAZ_PERF_CNT_EN: three RAW stalls plus one taken branch -> stall_cnt=5, redirect_cnt=1; force 70000 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage DataCycle core: RAW scoreboard stalls, branch shadow, memory hold.
// Optional perf counters: define HAZ_PERF_CNT_EN to add stall_cnt / redirect_cnt.
module pipe_hazard_ctrl #(
    parameter int unsigned RIDX_W    = 5,
    parameter int unsigned BR_SHADOW = 3,
    parameter int unsigned ZERO_REG  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RIDX_W-1:0] id_rx,
    input  logic [RIDX_W-1:0] id_ry,
    input  logic              id_rx_used,
    input  logic              id_ry_used,
    input  logic [RIDX_W-1:0] id_rz,
    input  logic              id_rin,
    input  logic              id_is_ctrl,
    input  logic              wb_mp0,
    input  logic              ext_hold,
    output logic              pc_stall,
    output logic              p1_stall,
    output logic              p2_stall,
    output logic              p3_stall,
    output logic              p4_stall,
    output logic              p1_flush,
    output logic              p2_flush,
    output logic [1:0]        ctrl_state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       redirect_cnt
`endif
);

    localparam int unsigned     CNT_W    = (BR_SHADOW > 2) ? $clog2(BR_SHADOW) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BR_SHADOW - 1);
    localparam bit              ZERO_EN  = (ZERO_REG != 0);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_SHADOW = 2'b01,
        ST_HOLD   = 2'b10
    } state_t;

    state_t            state_q, state_d;
    state_t            saved_q, saved_d;
    state_t            eff_state;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_eval;
    logic              taken_c;

    logic              sb_ex_vld_q, sb_mem_vld_q, sb_wb_vld_q;
    logic [RIDX_W-1:0] sb_ex_idx_q, sb_mem_idx_q, sb_wb_idx_q;
    logic              sb_ex_vld_d;

    logic              rx_hit, ry_hit, hazard_c;

    // A source hits when any valid in-flight write targets it (r0 exempt when ZERO_EN).
    assign rx_hit = id_rx_used && !(ZERO_EN && (id_rx == '0)) &&
                    ((sb_ex_vld_q  && (sb_ex_idx_q  == id_rx)) ||
                     (sb_mem_vld_q && (sb_mem_idx_q == id_rx)) ||
                     (sb_wb_vld_q  && (sb_wb_idx_q  == id_rx)));
    assign ry_hit = id_ry_used && !(ZERO_EN && (id_ry == '0)) &&
                    ((sb_ex_vld_q  && (sb_ex_idx_q  == id_ry)) ||
                     (sb_mem_vld_q && (sb_mem_idx_q == id_ry)) ||
                     (sb_wb_vld_q  && (sb_wb_idx_q  == id_ry)));
    assign hazard_c = rx_hit || ry_hit;

    assign ctrl_state = state_q;

    // HOLD behaves as the saved state once ext_hold drops, so no extra recovery cycle.
    assign eff_state = (state_q == ST_HOLD) ? saved_q : state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            saved_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        pc_stall = 1'b0;
        p1_stall = 1'b0;
        p2_stall = 1'b0;
        p3_stall = 1'b0;
        p4_stall = 1'b0;
        p1_flush = 1'b0;
        p2_flush = 1'b0;
        state_d  = state_q;
        saved_d  = saved_q;
        cnt_d    = cnt_q;
        run_eval = 1'b0;
        taken_c  = 1'b0;

        if (ext_hold) begin
            pc_stall = 1'b1;
            p1_stall = 1'b1;
            p2_stall = 1'b1;
            p3_stall = 1'b1;
            p4_stall = 1'b1;
            state_d  = ST_HOLD;
            saved_d  = eff_state;
        end else begin
            if (eff_state == ST_SHADOW) begin
                if (cnt_q != '0) begin
                    pc_stall = 1'b1;
                    p1_stall = 1'b1;
                    p2_flush = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                    state_d  = ST_SHADOW;
                end else if (wb_mp0) begin
                    p1_flush = 1'b1;
                    p2_flush = 1'b1;
                    taken_c  = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    run_eval = 1'b1;
                end
            end else begin
                run_eval = 1'b1;
            end

            // Not-taken resolution falls through to the normal RUN decision in the same cycle.
            if (run_eval) begin
                state_d = ST_RUN;
                if (hazard_c) begin
                    pc_stall = 1'b1;
                    p1_stall = 1'b1;
                    p2_flush = 1'b1;
                end else if (id_is_ctrl) begin
                    cnt_d   = CNT_LOAD;
                    state_d = ST_SHADOW;
                end
            end
        end
    end

    assign sb_ex_vld_d = !ext_hold && !p2_flush && id_rin && !(ZERO_EN && (id_rz == '0));

    // Scoreboard follows the instruction from EX to WB; frozen with the pipe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_ex_vld_q  <= 1'b0;
            sb_mem_vld_q <= 1'b0;
            sb_wb_vld_q  <= 1'b0;
            sb_ex_idx_q  <= '0;
            sb_mem_idx_q <= '0;
            sb_wb_idx_q  <= '0;
        end else if (!ext_hold) begin
            sb_wb_vld_q  <= sb_mem_vld_q;
            sb_wb_idx_q  <= sb_mem_idx_q;
            sb_mem_vld_q <= sb_ex_vld_q;
            sb_mem_idx_q <= sb_ex_idx_q;
            sb_ex_vld_q  <= sb_ex_vld_d;
            sb_ex_idx_q  <= id_rz;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Saturating event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (pc_stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (taken_c && (redirect_cnt != 16'hFFFF)) begin
                redirect_cnt <= redirect_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (optionally with HAZ_PERF_CNT_EN).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rx, id_ry, id_rz;
    logic       id_rx_used, id_ry_used, id_rin, id_is_ctrl, wb_mp0, ext_hold;
    logic       pc_stall, p1_stall, p2_stall, p3_stall, p4_stall, p1_flush, p2_flush;
    logic [1:0] ctrl_state;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt, redirect_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // {state, pc_stall, p1_stall, p2_stall, p3_stall, p4_stall, p1_flush, p2_flush}
    localparam logic [8:0] RUN_IDLE  = 9'b00_00000_00;
    localparam logic [8:0] RUN_STALL = 9'b00_11000_01;
    localparam logic [8:0] SH_STALL  = 9'b01_11000_01;
    localparam logic [8:0] SH_TAKEN  = 9'b01_00000_11;
    localparam logic [8:0] SH_NTAKEN = 9'b01_00000_00;
    localparam logic [8:0] HOLD_SH   = 9'b01_11111_00;
    localparam logic [8:0] HOLD_HD   = 9'b10_11111_00;
    localparam logic [8:0] HD_STALL  = 9'b10_11000_01;

    logic [8:0] obs_v;
    assign obs_v = {ctrl_state, pc_stall, p1_stall, p2_stall, p3_stall, p4_stall, p1_flush, p2_flush};

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .id_rx      (id_rx),
        .id_ry      (id_ry),
        .id_rx_used (id_rx_used),
        .id_ry_used (id_ry_used),
        .id_rz      (id_rz),
        .id_rin     (id_rin),
        .id_is_ctrl (id_is_ctrl),
        .wb_mp0     (wb_mp0),
        .ext_hold   (ext_hold),
        .pc_stall   (pc_stall),
        .p1_stall   (p1_stall),
        .p2_stall   (p2_stall),
        .p3_stall   (p3_stall),
        .p4_stall   (p4_stall),
        .p1_flush   (p1_flush),
        .p2_flush   (p2_flush),
        .ctrl_state (ctrl_state)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .redirect_cnt (redirect_cnt)
`endif
    );

    // One cycle: sample on the falling edge, then advance to just past the next rising edge.
    task automatic chk(input string tag, input logic [8:0] exp);
        @(negedge clk);
        n_cmp++;
        assert (obs_v === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs_v, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr_id();
        id_rx = '0; id_ry = '0; id_rz = '0;
        id_rx_used = 1'b0; id_ry_used = 1'b0; id_rin = 1'b0;
        id_is_ctrl = 1'b0; wb_mp0 = 1'b0; ext_hold = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        clr_id();
        chk("reset", RUN_IDLE);
        rst = 1'b1;

        // RAW on Rx: producer r3, consumer stalls three cycles then issues
        id_rz = 5'd3; id_rin = 1'b1;
        chk("raw_prod", RUN_IDLE);
        clr_id(); id_rx = 5'd3; id_rx_used = 1'b1;
        chk("raw_s1", RUN_STALL);
        chk("raw_s2", RUN_STALL);
        chk("raw_s3", RUN_STALL);
        chk("raw_go", RUN_IDLE);

        // r0 never hazards
        clr_id(); id_rz = 5'd0; id_rin = 1'b1;
        chk("r0_prod", RUN_IDLE);
        clr_id(); id_rx = 5'd0; id_rx_used = 1'b1;
        chk("r0_read", RUN_IDLE);

        // RAW on Ry, and unused Rx field matching an in-flight write
        clr_id(); id_rz = 5'd4; id_rin = 1'b1;
        chk("ry_prod", RUN_IDLE);
        clr_id(); id_ry = 5'd4; id_ry_used = 1'b1; id_rx = 5'd4;
        chk("ry_s1", RUN_STALL);
        chk("ry_s2", RUN_STALL);
        chk("ry_s3", RUN_STALL);
        chk("ry_go", RUN_IDLE);
        clr_id(); id_rz = 5'd6; id_rin = 1'b1;
        chk("unused_prod", RUN_IDLE);
        clr_id(); id_rx = 5'd6; id_rx_used = 1'b0;
        chk("unused_rx", RUN_IDLE);
        clr_id();
        chk("drain1", RUN_IDLE);
        chk("drain2", RUN_IDLE);

        // Taken branch: b+1 writes r7 but must never reach EX
        id_is_ctrl = 1'b1;
        chk("tk_issue", RUN_IDLE);
        clr_id(); id_rz = 5'd7; id_rin = 1'b1; wb_mp0 = 1'b1;
        chk("tk_sh1", SH_STALL);
        wb_mp0 = 1'b0;
        chk("tk_sh2", SH_STALL);
        wb_mp0 = 1'b1;
        chk("tk_resolve", SH_TAKEN);
        clr_id(); id_rx = 5'd7; id_rx_used = 1'b1;
        chk("tk_no_r7", RUN_IDLE);

        // Not-taken branch: b+1 writing r9 issues on the resolution cycle
        clr_id(); id_is_ctrl = 1'b1;
        chk("nt_issue", RUN_IDLE);
        clr_id(); id_rz = 5'd9; id_rin = 1'b1;
        chk("nt_sh1", SH_STALL);
        chk("nt_sh2", SH_STALL);
        chk("nt_resolve", SH_NTAKEN);
        clr_id(); id_rx = 5'd9; id_rx_used = 1'b1;
        chk("nt_r9_s1", RUN_STALL);
        chk("nt_r9_s2", RUN_STALL);
        chk("nt_r9_s3", RUN_STALL);
        chk("nt_r9_go", RUN_IDLE);

        // ext_hold for four cycles with the shadow counter at 1
        clr_id(); id_is_ctrl = 1'b1;
        chk("hd_issue", RUN_IDLE);
        clr_id();
        chk("hd_sh1", SH_STALL);
        ext_hold = 1'b1; wb_mp0 = 1'b1;
        chk("hd_h1", HOLD_SH);
        chk("hd_h2", HOLD_HD);
        chk("hd_h3", HOLD_HD);
        chk("hd_h4", HOLD_HD);
        ext_hold = 1'b0; wb_mp0 = 1'b0;
        chk("hd_sh2", HD_STALL);
        wb_mp0 = 1'b1;
        chk("hd_resolve", SH_TAKEN);

        // Control transfer with a hazard waits in ID, only then enters SHADOW
        clr_id(); id_rz = 5'd2; id_rin = 1'b1;
        chk("pri_prod", RUN_IDLE);
        clr_id(); id_is_ctrl = 1'b1; id_rx = 5'd2; id_rx_used = 1'b1;
        chk("pri_s1", RUN_STALL);
        chk("pri_s2", RUN_STALL);
        chk("pri_s3", RUN_STALL);
        chk("pri_issue", RUN_IDLE);
        clr_id();
        chk("pri_sh1", SH_STALL);
        chk("pri_sh2", SH_STALL);
        chk("pri_resolve", SH_NTAKEN);

        // Reset mid-SHADOW (counter 2); branch wrote r5
        clr_id(); id_is_ctrl = 1'b1; id_rz = 5'd5; id_rin = 1'b1;
        chk("rs_issue", RUN_IDLE);
        clr_id();
        rst = 1'b0;
        chk("rs_async", RUN_IDLE);
        rst = 1'b1; id_rx = 5'd5; id_rx_used = 1'b1;
        chk("rs_no_r5", RUN_IDLE);
        clr_id();
        chk("rs_idle", RUN_IDLE);

`ifdef HAZ_PERF_CNT_EN
        rst = 1'b0;
        chk("pc_reset", RUN_IDLE);
        rst = 1'b1;
        id_rz = 5'd3; id_rin = 1'b1;
        chk("pc_prod", RUN_IDLE);
        clr_id(); id_rx = 5'd3; id_rx_used = 1'b1;
        chk("pc_s1", RUN_STALL);
        chk("pc_s2", RUN_STALL);
        chk("pc_s3", RUN_STALL);
        chk("pc_go", RUN_IDLE);
        clr_id(); id_is_ctrl = 1'b1;
        chk("pc_br", RUN_IDLE);
        clr_id();
        chk("pc_sh1", SH_STALL);
        chk("pc_sh2", SH_STALL);
        wb_mp0 = 1'b1;
        chk("pc_resolve", SH_TAKEN);
        clr_id();
        @(negedge clk);
        n_cmp++;
        assert (stall_cnt === 16'd5) else begin
            n_fail++;
            $error("FAIL stall_cnt5: observed %0d expected 5", stall_cnt);
        end
        n_cmp++;
        assert (redirect_cnt === 16'd1) else begin
            n_fail++;
            $error("FAIL redirect_cnt1: observed %0d expected 1", redirect_cnt);
        end
        @(posedge clk); #1;
        ext_hold = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        ext_hold = 1'b0;
        @(negedge clk);
        n_cmp++;
        assert (stall_cnt === 16'hFFFF) else begin
            n_fail++;
            $error("FAIL stall_sat: observed %h expected ffff", stall_cnt);
        end
        n_cmp++;
        assert (redirect_cnt === 16'd1) else begin
            n_fail++;
            $error("FAIL redirect_hold: observed %0d expected 1", redirect_cnt);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
